hex_seq_counter: RTL and testbench

HEX_SEQ_COUNTER -- requirements
Module: hex_seq_counter

---
 rtl/hex_seq_counter.sv | 147 ++++++++++++++
 tb/tb_hex_seq_counter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_seq_counter.sv
// Step-driven up/down counter with seven-segment (active-low) hex display outputs.
// Optional leading-zero blanking is compiled in with the HEX_SEQ_BLANK_EN macro.
module hex_seq_counter #(
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned MAX_COUNT = 255,
  parameter bit          WRAP      = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  step,
  input  logic                  dir,
  input  logic                  hold,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  limit
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned HW = 7 * DIGITS;
  localparam logic [W-1:0] MaxVal = W'(MAX_COUNT);

  typedef enum logic [1:0] {StIdle, StStep, StHold} state_e;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  function automatic logic [HW-1:0] encode(input logic [W-1:0] v);
    logic [HW-1:0] h;
    h = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      h[7*k +: 7] = seg7(v[4*k +: 4]);
`ifdef HEX_SEQ_BLANK_EN
      // A digit is blank when it and every more significant nibble are zero.
      if (k > 0 && (v >> (4 * k)) == '0) h[7*k +: 7] = 7'b1111111;
`endif
    end
    return h;
  endfunction

  localparam logic [HW-1:0] HexRst = encode('0);

  state_e         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [HW-1:0]  hex_q, hex_d;
  logic           limit_q, limit_d;
  logic           step_q, step_d;
  logic           arm_q, arm_d;
  logic           dir_q, dir_d;
  logic           step_edge;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    limit_d   = 1'b0;
    dir_d     = dir_q;
    step_d    = step;
    // After reset, step must be seen low once before an edge can count.
    arm_d     = arm_q | ~step;
    step_edge = step & ~step_q & arm_q;
    hex_d     = encode(count_q);

    if (load) begin
      state_d = StIdle;
      count_d = (load_val > MaxVal) ? MaxVal : load_val;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hold) begin
            state_d = StHold;
          end else if (step_edge) begin
            state_d = StStep;
            dir_d   = dir;
          end
        end
        StStep: begin
          state_d = hold ? StHold : StIdle;
          if (dir_q) begin
            if (count_q >= MaxVal) begin
              limit_d = 1'b1;
              count_d = WRAP ? '0 : MaxVal;
            end else begin
              count_d = count_q + 1'b1;
            end
          end else begin
            if (count_q == '0) begin
              limit_d = 1'b1;
              count_d = WRAP ? MaxVal : '0;
            end else begin
              count_d = count_q - 1'b1;
            end
          end
        end
        StHold: begin
          if (!hold) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      count_q <= '0;
      hex_q   <= HexRst;
      limit_q <= 1'b0;
      step_q  <= 1'b0;
      arm_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hex_q   <= hex_d;
      limit_q <= limit_d;
      step_q  <= step_d;
      arm_q   <= arm_d;
      dir_q   <= dir_d;
    end
  end

  assign count = count_q;
  assign hex   = hex_q;
  assign limit = limit_q;

endmodule

// File: tb/tb_hex_seq_counter.sv
// Scoreboard bench for hex_seq_counter: three instances (wrap/200, wrap/9, saturate/9) share
// stimulus; expected count/limit events are queued per instance and popped by monitors.
module tb_hex_seq_counter;

  typedef struct packed {
    logic [7:0] cnt;
    logic       lim;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        step = 1'b0, dir = 1'b0, hold = 1'b0, load = 1'b0;
  logic [7:0]  load_val = 8'h00;
  logic [7:0]  count_a, count_b, count_c;
  logic [13:0] hex_a, hex_b, hex_c;
  logic        limit_a, limit_b, limit_c;

  int n_pass = 0;
  int n_total = 0;
  bit mon_en = 1'b0;

  ev_t q_a[$], q_b[$], q_c[$];
  int  last_exp[3] = '{0, 0, 0};

  always #5 clk = ~clk;

  hex_seq_counter #(.DIGITS(2), .MAX_COUNT(200), .WRAP(1'b1)) u_a (
    .clk(clk), .reset_n(reset_n), .step(step), .dir(dir), .hold(hold), .load(load),
    .load_val(load_val), .count(count_a), .hex(hex_a), .limit(limit_a)
  );
  hex_seq_counter #(.DIGITS(2), .MAX_COUNT(9), .WRAP(1'b1)) u_b (
    .clk(clk), .reset_n(reset_n), .step(step), .dir(dir), .hold(hold), .load(load),
    .load_val(load_val), .count(count_b), .hex(hex_b), .limit(limit_b)
  );
  hex_seq_counter #(.DIGITS(2), .MAX_COUNT(9), .WRAP(1'b0)) u_c (
    .clk(clk), .reset_n(reset_n), .step(step), .dir(dir), .hold(hold), .load(load),
    .load_val(load_val), .count(count_c), .hex(hex_c), .limit(limit_c)
  );

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [13:0] hex_ref(input logic [7:0] v);
    logic [6:0] hi;
    hi = seg_ref(v[7:4]);
`ifdef HEX_SEQ_BLANK_EN
    if (v[7:4] == 4'h0) hi = 7'h7F;
`endif
    return {hi, seg_ref(v[3:0])};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic unexpected(input string name, input int act);
    n_total++;
    $display("FAIL %s: unexpected output event, count=%0d", name, act);
  endtask

  task automatic push1(input int i, input int c, input bit l);
    ev_t e;
    e.cnt = 8'(c);
    e.lim = l;
    if (l || c != last_exp[i]) begin
      case (i)
        0: q_a.push_back(e);
        1: q_b.push_back(e);
        default: q_c.push_back(e);
      endcase
    end
    last_exp[i] = c;
  endtask

  task automatic exp3(input int ca, input bit la, input int cb, input bit lb,
                      input int cc, input bit lc);
    push1(0, ca, la);
    push1(1, cb, lb);
    push1(2, cc, lc);
  endtask

  task automatic step_pulse(input bit d);
    @(posedge clk); #1;
    dir = d; step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    @(posedge clk); #1;
    load = 1'b1; load_val = v;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // Monitors: an output event is a count change or a limit pulse.
  logic [7:0] prev_a = 8'h00, prev_b = 8'h00, prev_c = 8'h00, hex_ref_val = 8'h00;
  bit         hex_pend = 1'b0;

  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (hex_pend) chk("hex_a", int'(hex_a), int'(hex_ref(hex_ref_val)));
      hex_pend = 1'b0;
      if (count_a != prev_a || limit_a) begin
        if (q_a.size() == 0) unexpected("event_a", int'(count_a));
        else begin
          e = q_a.pop_front();
          chk("count_a", int'(count_a), int'(e.cnt));
          chk("limit_a", int'(limit_a), int'(e.lim));
        end
        hex_pend = 1'b1;
        hex_ref_val = count_a;
      end
      prev_a = count_a;
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (count_b != prev_b || limit_b) begin
        if (q_b.size() == 0) unexpected("event_b", int'(count_b));
        else begin
          e = q_b.pop_front();
          chk("count_b", int'(count_b), int'(e.cnt));
          chk("limit_b", int'(limit_b), int'(e.lim));
        end
      end
      prev_b = count_b;
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (count_c != prev_c || limit_c) begin
        if (q_c.size() == 0) unexpected("event_c", int'(count_c));
        else begin
          e = q_c.pop_front();
          chk("count_c", int'(count_c), int'(e.cnt));
          chk("limit_c", int'(limit_c), int'(e.lim));
        end
      end
      prev_c = count_c;
    end
  end

  initial begin
    logic [6:0] hi_exp;
`ifdef HEX_SEQ_BLANK_EN
    hi_exp = 7'h7F;
`else
    hi_exp = 7'h40;
`endif
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_count_a", int'(count_a), 0);
    chk("rst_limit_a", int'(limit_a), 0);
    chk("rst_hex_a", int'(hex_a), int'({hi_exp, 7'h40}));
    chk("rst_count_c", int'(count_c), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (2) @(posedge clk);

    // Three up steps, then one down
    exp3(1, 0, 1, 0, 1, 0);  step_pulse(1'b1);
    exp3(2, 0, 2, 0, 2, 0);  step_pulse(1'b1);
    exp3(3, 0, 3, 0, 3, 0);  step_pulse(1'b1);
    chk("hex_digit0_at_3", int'(hex_a[6:0]), int'(7'b0110000));
    exp3(2, 0, 2, 0, 2, 0);  step_pulse(1'b0);

    // Boundaries at MAX_COUNT and 0
    exp3(9, 0, 9, 0, 9, 0);     do_load(8'd9);
    exp3(10, 0, 0, 1, 9, 1);    step_pulse(1'b1);
    exp3(9, 0, 9, 1, 8, 0);     step_pulse(1'b0);
    exp3(0, 0, 0, 0, 0, 0);     do_load(8'd0);
    exp3(200, 1, 9, 1, 0, 1);   step_pulse(1'b0);

    // Hold discards step edges
    @(posedge clk); #1 hold = 1'b1;
    repeat (2) @(posedge clk);
    repeat (4) step_pulse(1'b1);
    @(posedge clk); #1 hold = 1'b0;
    repeat (4) @(posedge clk);

    // Step held high for 20 cycles advances once
    exp3(0, 1, 0, 1, 1, 0);
    @(posedge clk); #1 dir = 1'b1; step = 1'b1;
    repeat (20) @(posedge clk);
    #1 step = 1'b0;
    repeat (4) @(posedge clk);

    // Loads and clamping
    exp3(5, 0, 5, 0, 5, 0);       do_load(8'h05);
    chk("hex_upper_digit_at_5", int'(hex_a[13:7]), int'(hi_exp));
    exp3(200, 0, 9, 0, 9, 0);     do_load(8'hFF);
    exp3(5, 0, 5, 0, 5, 0);       do_load(8'h05);
    exp3(200, 0, 9, 0, 9, 0);     do_load(8'hC8);
    chk("hex_at_200", int'(hex_a), int'({7'b1000110, 7'b0000000}));

    // Load coincident with a step edge: load wins, edge discarded
    exp3(3, 0, 3, 0, 3, 0);
    @(posedge clk); #1 load = 1'b1; load_val = 8'd3; dir = 1'b1; step = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    repeat (5) @(posedge clk);
    #1 step = 1'b0;
    repeat (3) @(posedge clk);

    // Reset during STEP aborts; step still high after release must not advance
    exp3(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 dir = 1'b1; step = 1'b1;
    @(posedge clk); #1 reset_n = 1'b0;
    #1 chk("reset_mid_step", int'(count_a), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 step = 1'b0;
    repeat (3) @(posedge clk);
    exp3(1, 0, 1, 0, 1, 0);  step_pulse(1'b1);

    repeat (4) @(posedge clk);
    chk("pending_a", q_a.size(), 0);
    chk("pending_b", q_b.size(), 0);
    chk("pending_c", q_c.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
